// File: rtl/mole_pkg.sv
// Shared definitions for the Whac-A-Mole round controller.
//   state_e : game FSM states
//   RAND_W  : width of the external LFSR value
package mole_pkg;

    localparam int RAND_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        MOLE_UP    = 2'd2,
        GAME_OVER  = 2'd3
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a vector of synchronised levels.
//   clk, rst_n : clock, asynchronous active-low reset
//   level      : input levels (already synchronised/debounced)
//   rise       : per-bit rising edge, combinational from level and its
//                registered copy (rise = level & ~level_q)
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] level_q;

    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/mole_round_fsm.sv
// Whac-A-Mole game core: random pre-mole delay, one lit mole per round,
// reaction-time measurement in ms, hit/miss/round bookkeeping.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ms_tick         : one-cycle strobe per millisecond
//   start           : level; rising edge starts a game from IDLE/GAME_OVER
//   buttons         : debounced, synchronised button levels
//   rand_value      : free-running LFSR value
//   mole_leds       : one-hot lit mole, zero outside MOLE_UP
//   reaction_ms     : last round's reaction time (held)
//   reaction_valid  : one-cycle pulse when reaction_ms updates
//   timeout         : round ended by timeout (held, qualifies the pulse)
//   hits, misses    : game scores; misses saturates at 255
//   round_active    : high in WAIT_DELAY and MOLE_UP
//   game_over       : high in GAME_OVER
module mole_round_fsm
    import mole_pkg::*;
#(
    parameter int N_MOLES      = 4,
    parameter int MAX_MS       = 2047,
    parameter int MIN_DELAY_MS = 500,
    parameter int N_ROUNDS     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ms_tick,
    input  logic                              start,
    input  logic [N_MOLES-1:0]                buttons,
    input  logic [RAND_W-1:0]                 rand_value,
    output logic [N_MOLES-1:0]                mole_leds,
    output logic [$clog2(MAX_MS+1)-1:0]       reaction_ms,
    output logic                              reaction_valid,
    output logic                              timeout,
    output logic [$clog2(N_ROUNDS+1)-1:0]     hits,
    output logic [7:0]                        misses,
    output logic                              round_active,
    output logic                              game_over
);

    localparam int RMS_W = $clog2(MAX_MS + 1);
    localparam int HIT_W = $clog2(N_ROUNDS + 1);
    localparam int TGT_W = $clog2(N_MOLES);
    // Delay counter must hold MIN_DELAY_MS plus the largest 10-bit random offset.
    localparam int DLY_W = $clog2(MIN_DELAY_MS + 1024);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e             state_q,          state_d;
    logic [DLY_W-1:0]   delay_q,          delay_d;
    logic [TGT_W-1:0]   target_q,         target_d;
    logic [RMS_W-1:0]   react_q,          react_d;
    logic [HIT_W-1:0]   round_q,          round_d;
    logic [HIT_W-1:0]   hits_q,           hits_d;
    logic [7:0]         misses_q,         misses_d;
    logic [RMS_W-1:0]   reaction_ms_q,    reaction_ms_d;
    logic               timeout_q,        timeout_d;
    logic               reaction_valid_q, reaction_valid_d;

    logic [N_MOLES-1:0] btn_rise;
    logic [0:0]         start_rise;
    logic [N_MOLES-1:0] tgt_onehot;
    logic [DLY_W-1:0]   new_delay;
    logic [TGT_W-1:0]   new_target;
    logic               end_round;
    logic               unused_rand;

    edge_detect #(.WIDTH(N_MOLES)) u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (buttons),
        .rise  (btn_rise)
    );

    edge_detect #(.WIDTH(1)) u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (start),
        .rise  (start_rise)
    );

    // Round parameters drawn from the LFSR at the moment a round is loaded.
    assign new_delay   = DLY_W'(MIN_DELAY_MS) + DLY_W'(rand_value[9:0]);
    assign new_target  = rand_value[RAND_W-1 -: TGT_W];
    assign unused_rand = ^rand_value;

    assign tgt_onehot  = N_MOLES'(1) << target_q;

    always_comb begin
        state_d          = state_q;
        delay_d          = delay_q;
        target_d         = target_q;
        react_d          = react_q;
        round_d          = round_q;
        hits_d           = hits_q;
        misses_d         = misses_q;
        reaction_ms_d    = reaction_ms_q;
        timeout_d        = timeout_q;
        reaction_valid_d = 1'b0;
        end_round        = 1'b0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise[0]) begin
                    hits_d   = '0;
                    misses_d = '0;
                    round_d  = '0;
                    delay_d  = new_delay;
                    target_d = new_target;
                    state_d  = WAIT_DELAY;
                end
            end

            WAIT_DELAY: begin
                // An early press beats a simultaneous delay expiry.
                if (|btn_rise) begin
                    misses_d = sat_inc8(misses_q);
                    delay_d  = new_delay;
                end else if (ms_tick) begin
                    if (delay_q == '0) begin
                        react_d = '0;
                        state_d = MOLE_UP;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end

            MOLE_UP: begin
                if (ms_tick && (react_q != RMS_W'(MAX_MS))) begin
                    react_d = react_q + RMS_W'(1);
                end
                // Exactly the target bit is a hit, even on the timeout tick;
                // any other non-zero edge pattern is a miss.
                if (btn_rise == tgt_onehot) begin
                    reaction_ms_d    = react_q;
                    reaction_valid_d = 1'b1;
                    timeout_d        = 1'b0;
                    hits_d           = hits_q + HIT_W'(1);
                    end_round        = 1'b1;
                end else if (|btn_rise) begin
                    misses_d = sat_inc8(misses_q);
                end else if (ms_tick && (react_q == RMS_W'(MAX_MS))) begin
                    reaction_ms_d    = RMS_W'(MAX_MS);
                    reaction_valid_d = 1'b1;
                    timeout_d        = 1'b1;
                    misses_d         = sat_inc8(misses_q);
                    end_round        = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (end_round) begin
            round_d = round_q + HIT_W'(1);
            if (round_q == HIT_W'(N_ROUNDS - 1)) begin
                state_d = GAME_OVER;
            end else begin
                delay_d  = new_delay;
                target_d = new_target;
                state_d  = WAIT_DELAY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            delay_q          <= '0;
            target_q         <= '0;
            react_q          <= '0;
            round_q          <= '0;
            hits_q           <= '0;
            misses_q         <= '0;
            reaction_ms_q    <= '0;
            timeout_q        <= 1'b0;
            reaction_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            delay_q          <= delay_d;
            target_q         <= target_d;
            react_q          <= react_d;
            round_q          <= round_d;
            hits_q           <= hits_d;
            misses_q         <= misses_d;
            reaction_ms_q    <= reaction_ms_d;
            timeout_q        <= timeout_d;
            reaction_valid_q <= reaction_valid_d;
        end
    end

    assign mole_leds      = (state_q == MOLE_UP) ? tgt_onehot : '0;
    assign reaction_ms    = reaction_ms_q;
    assign reaction_valid = reaction_valid_q;
    assign timeout        = timeout_q;
    assign hits           = hits_q;
    assign misses         = misses_q;
    assign round_active   = (state_q == WAIT_DELAY) || (state_q == MOLE_UP);
    assign game_over      = (state_q == GAME_OVER);

endmodule

// File: tb/tb_mole_round_fsm.sv
module tb_mole_round_fsm;

    localparam int N_MOLES      = 4;
    localparam int MAX_MS       = 2047;
    localparam int MIN_DELAY_MS = 500;
    localparam int N_ROUNDS     = 8;

    logic        clk;
    logic        rst_n;
    logic        ms_tick;
    logic        start;
    logic [3:0]  buttons;
    logic [15:0] rand_value;
    logic [3:0]  mole_leds;
    logic [10:0] reaction_ms;
    logic        reaction_valid;
    logic        timeout;
    logic [3:0]  hits;
    logic [7:0]  misses;
    logic        round_active;
    logic        game_over;

    mole_round_fsm #(
        .N_MOLES      (N_MOLES),
        .MAX_MS       (MAX_MS),
        .MIN_DELAY_MS (MIN_DELAY_MS),
        .N_ROUNDS     (N_ROUNDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ms_tick        (ms_tick),
        .start          (start),
        .buttons        (buttons),
        .rand_value     (rand_value),
        .mole_leds      (mole_leds),
        .reaction_ms    (reaction_ms),
        .reaction_valid (reaction_valid),
        .timeout        (timeout),
        .hits           (hits),
        .misses         (misses),
        .round_active   (round_active),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row per round: LFSR value loaded for the round, press
    // delay after the mole lights (0 = never press), button pattern and
    // the expected results.
    typedef struct {
        logic [15:0] rnd;
        int          press_after;
        logic [3:0]  btn;
        int          exp_ms;
        logic        exp_to;
        int          exp_hits;
        int          exp_misses;
    } round_vec_t;

    typedef struct {
        int   ms;
        logic to;
    } sb_t;

    round_vec_t tbl[8];
    sb_t        sb_q[$];
    sb_t        sb_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       rv_prev  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every reaction_valid pulse must match the oldest
    // expectation, and pulses never come back to back.
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (reaction_valid) begin
                chk("rv_not_consecutive", int'(rv_prev), 0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rv_unexpected: got pulse ms=%0d, expected no pulse", reaction_ms);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_reaction_ms", int'(reaction_ms), sb_e.ms);
                    chk("sb_timeout", int'(timeout), int'(sb_e.to));
                end
            end
            rv_prev = reaction_valid;
        end
    end

    // Start high for one cycle; returns just after the edge that ends it.
    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // Counts cycles with the LED off until the mole lights (bounded).
    task automatic wait_mole(output int zeros);
        zeros = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (mole_leds != 4'b0000) return;
            zeros++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_mole_bound: got no mole after %0d cycles, expected a mole", zeros);
    endtask

    // Press pattern b for one cycle after 'after' clock edges; returns at the
    // negedge of the cycle following the press, when outputs reflect it.
    task automatic press(input int after, input logic [3:0] b);
        repeat (after) @(posedge clk);
        #1; buttons = b;
        @(posedge clk); #1; buttons = 4'b0000;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int z;
        int h;
        int exp_z;

        tbl[0] = '{16'h0000,  37, 4'b0001,   37, 1'b0, 1, 0};
        tbl[1] = '{16'h4005,   3, 4'b0010,    3, 1'b0, 2, 0};
        tbl[2] = '{16'h8010,   1, 4'b0100,    1, 1'b0, 3, 0};
        tbl[3] = '{16'hC3FF, 100, 4'b1000,  100, 1'b0, 4, 0};
        tbl[4] = '{16'h0002,   0, 4'b0000, 2047, 1'b1, 4, 1};
        tbl[5] = '{16'h4001, 250, 4'b0010,  250, 1'b0, 5, 1};
        tbl[6] = '{16'h8000,  12, 4'b0100,   12, 1'b0, 6, 1};
        tbl[7] = '{16'hC000,   7, 4'b1000,    7, 1'b0, 7, 1};

        rst_n = 1'b0; start = 1'b0; buttons = 4'b0000; ms_tick = 1'b1; rand_value = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_leds", int'(mole_leds), 0);
        chk("rst_hits", int'(hits), 0);
        chk("rst_misses", int'(misses), 0);
        chk("rst_rv", int'(reaction_valid), 0);
        chk("rst_ms", int'(reaction_ms), 0);
        chk("rst_active", int'(round_active), 0);
        chk("rst_game_over", int'(game_over), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Game 1: table-driven rounds, including a timeout round.
        rand_value = tbl[0].rnd;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            wait_mole(z);
            exp_z = (i == 0) ? (MIN_DELAY_MS + 1 + int'(tbl[i].rnd[9:0]))
                             : (MIN_DELAY_MS - 1 + int'(tbl[i].rnd[9:0]));
            chk($sformatf("delay_r%0d", i), z, exp_z);
            chk($sformatf("led_r%0d", i), int'(mole_leds), 1 << tbl[i].rnd[15:14]);
            chk($sformatf("active_r%0d", i), int'(round_active), 1);
            if (i < 7) rand_value = tbl[i+1].rnd;
            if (tbl[i].press_after > 0) begin
                sb_q.push_back('{tbl[i].exp_ms, tbl[i].exp_to});
                press(tbl[i].press_after, tbl[i].btn);
            end else begin
                sb_q.push_back('{MAX_MS, 1'b1});
                h = 0;
                while (mole_leds != 4'b0000 && h < 2100) begin
                    @(negedge clk);
                    h++;
                end
                chk("timeout_len", h, MAX_MS + 1);
            end
            chk($sformatf("rv_r%0d", i), int'(reaction_valid), 1);
            chk($sformatf("led_off_r%0d", i), int'(mole_leds), 0);
            chk($sformatf("hits_r%0d", i), int'(hits), tbl[i].exp_hits);
            chk($sformatf("misses_r%0d", i), int'(misses), tbl[i].exp_misses);
            @(negedge clk);
            chk($sformatf("rv_drop_r%0d", i), int'(reaction_valid), 0);
            chk($sformatf("ms_hold_r%0d", i), int'(reaction_ms), tbl[i].exp_ms);
            chk($sformatf("to_hold_r%0d", i), int'(timeout), int'(tbl[i].exp_to));
        end
        chk("g1_game_over", int'(game_over), 1);
        chk("g1_active", int'(round_active), 0);
        press(3, 4'b1111);
        chk("g1_ignore_hits", int'(hits), 7);
        chk("g1_ignore_misses", int'(misses), 1);
        chk("g1_ignore_leds", int'(mole_leds), 0);

        // Game 2: early press, multi-button miss, eight hits to game over.
        rand_value = 16'h0000;
        pulse_start();
        @(negedge clk);
        chk("g2_clr_hits", int'(hits), 0);
        chk("g2_clr_misses", int'(misses), 0);
        chk("g2_game_over", int'(game_over), 0);
        chk("g2_active", int'(round_active), 1);
        rand_value = 16'h4003;
        press(9, 4'b0100);
        chk("early_misses", int'(misses), 1);
        chk("early_leds", int'(mole_leds), 0);
        chk("early_active", int'(round_active), 1);
        wait_mole(z);
        chk("early_reload", z, MIN_DELAY_MS + 3);
        chk("early_keep_target", int'(mole_leds), 4'b0001);
        rand_value = 16'h4000;
        sb_q.push_back('{5, 1'b0});
        press(5, 4'b0001);
        chk("g2_r1_hits", int'(hits), 1);
        wait_mole(z);
        chk("g2_r2_delay", z, MIN_DELAY_MS);
        chk("g2_r2_led", int'(mole_leds), 4'b0010);
        press(4, 4'b1010);
        chk("combo_misses", int'(misses), 2);
        chk("combo_hits", int'(hits), 1);
        chk("combo_led", int'(mole_leds), 4'b0010);
        rand_value = 16'h0000;
        sb_q.push_back('{8, 1'b0});
        press(3, 4'b0010);
        chk("combo_then_hit", int'(hits), 2);
        for (int j = 0; j < 6; j++) begin
            pulse_start();
            wait_mole(z);
            chk($sformatf("g2_start_ign_delay%0d", j), z, MIN_DELAY_MS - 1);
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            sb_q.push_back('{4, 1'b0});
            press(2, 4'b0001);
            chk($sformatf("g2_hits%0d", j), int'(hits), 3 + j);
            chk($sformatf("g2_misses%0d", j), int'(misses), 2);
        end
        chk("g2_game_over", int'(game_over), 1);
        chk("g2_final_hits", int'(hits), 8);
        chk("g2_over_active", int'(round_active), 0);
        press(2, 4'b0001);
        chk("g2_ignore_hits", int'(hits), 8);

        // Game 3: no progress without ms_tick, then reset during MOLE_UP.
        ms_tick = 1'b0;
        pulse_start();
        repeat (600) @(negedge clk);
        chk("notick_leds", int'(mole_leds), 0);
        chk("notick_active", int'(round_active), 1);
        chk("g3_clr_hits", int'(hits), 0);
        @(posedge clk); #1; ms_tick = 1'b1;
        wait_mole(z);
        chk("notick_delay", z, MIN_DELAY_MS + 1);
        press(3, 4'b1000);
        chk("g3_miss", int'(misses), 1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_leds", int'(mole_leds), 0);
        chk("mid_rst_misses", int'(misses), 0);
        chk("mid_rst_hits", int'(hits), 0);
        chk("mid_rst_ms", int'(reaction_ms), 0);
        chk("mid_rst_active", int'(round_active), 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_active", int'(round_active), 0);
        chk("post_rst_rv", int'(reaction_valid), 0);
        press(2, 4'b0001);
        chk("idle_ignore_hits", int'(hits), 0);
        chk("idle_ignore_misses", int'(misses), 0);
        chk("idle_leds", int'(mole_leds), 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
